// File: rtl/i2c_dac_target.sv
`timescale 1ns/1ps
// I2C target that loads a 12-bit DAC code and 2 power-down bits from byte pairs.
// Optional readback of the loaded values is enabled by defining I2C_DAC_READBACK_EN.
module i2c_dac_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h62,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic [11:0] dac_out,
    output logic [1:0]  pd,
    output logic        update,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_BYTE  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
`ifdef I2C_DAC_READBACK_EN
    localparam logic [2:0] ST_RD_BYTE  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
`endif
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;
    logic [7:0]             w_next_byte;

    logic [2:0]  r_state;
    logic [6:0]  r_shift;
    logic [3:0]  r_bitcnt;
    logic [5:0]  r_b1;
    logic        r_have_b1;
    logic        r_sda_low;
    logic [11:0] r_dac;
    logic [1:0]  r_pd;
    logic        r_update;
    logic        r_busy;
`ifdef I2C_DAC_READBACK_EN
    logic        r_rw;
    logic        r_rd_lo;
    logic        r_rd_ack;
    logic [7:0]  w_rd_byte;

    assign w_rd_byte = r_rd_lo ? r_dac[7:0] : {2'b00, r_pd, r_dac[11:8]};
`endif

    assign w_scl       = r_scl_sync[SYNC_STAGES-1];
    assign w_sda       = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise  = w_scl & ~r_scl_prev;
    assign w_scl_fall  = ~w_scl & r_scl_prev;
    assign w_start     = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign w_stop      = r_scl_prev & w_scl & ~r_sda_prev & w_sda;
    assign w_next_byte = {r_shift, w_sda};

    assign sda     = r_sda_low ? 1'b0 : 1'bz;
    assign dac_out = r_dac;
    assign pd      = r_pd;
    assign update  = r_update;
    assign busy    = r_busy;

    // Bus input synchronizers and one-cycle-delayed copies for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= {SYNC_STAGES{1'b1}};
            r_sda_sync <= {SYNC_STAGES{1'b1}};
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    // Protocol FSM: address match, byte shifting, ACK drive and DAC register load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= 7'h00;
            r_bitcnt  <= 4'd0;
            r_b1      <= 6'h00;
            r_have_b1 <= 1'b0;
            r_sda_low <= 1'b0;
            r_dac     <= 12'h000;
            r_pd      <= 2'b00;
            r_update  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef I2C_DAC_READBACK_EN
            r_rw      <= 1'b0;
            r_rd_lo   <= 1'b0;
            r_rd_ack  <= 1'b0;
`endif
        end else begin
            r_update <= 1'b0;
            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bitcnt  <= 4'd0;
                r_sda_low <= 1'b0;
                r_have_b1 <= 1'b0;
`ifdef I2C_DAC_READBACK_EN
                r_rd_lo   <= 1'b0;
`endif
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_bitcnt  <= 4'd0;
                r_sda_low <= 1'b0;
                r_have_b1 <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_next_byte[6:0];
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= 4'd0;
                                if (w_next_byte[7:1] == TARGET_ADDR) begin
`ifdef I2C_DAC_READBACK_EN
                                    r_rw    <= w_next_byte[0];
                                    r_state <= ST_ADDR_ACK;
                                    r_busy  <= 1'b1;
`else
                                    // Reads are refused when the readback path is not built.
                                    r_state <= w_next_byte[0] ? ST_IGNORE : ST_ADDR_ACK;
                                    r_busy  <= ~w_next_byte[0];
`endif
                                end else begin
                                    r_state <= ST_IGNORE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        // First falling edge starts the ACK, the second one ends it.
                        if (w_scl_fall) begin
                            if (!r_sda_low) begin
                                r_sda_low <= 1'b1;
                            end else begin
                                r_sda_low <= 1'b0;
                                r_state   <= ST_WR_BYTE;
`ifdef I2C_DAC_READBACK_EN
                                if (r_rw) begin
                                    r_shift   <= w_rd_byte[6:0];
                                    r_sda_low <= ~w_rd_byte[7];
                                    r_rd_lo   <= ~r_rd_lo;
                                    r_state   <= ST_RD_BYTE;
                                end
`endif
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift <= w_next_byte[6:0];
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= 4'd0;
                                r_state  <= ST_WR_ACK;
                                if (!r_have_b1) begin
                                    r_b1      <= w_next_byte[5:0];
                                    r_have_b1 <= 1'b1;
                                end else begin
                                    r_dac     <= {r_b1[3:0], w_next_byte};
                                    r_pd      <= r_b1[5:4];
                                    r_update  <= 1'b1;
                                    r_have_b1 <= 1'b0;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end
`ifdef I2C_DAC_READBACK_EN
                    ST_RD_BYTE: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_bitcnt  <= 4'd0;
                                r_sda_low <= 1'b0;
                                r_state   <= ST_RD_ACK;
                            end else begin
                                r_sda_low <= ~r_shift[6];
                                r_shift   <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_rd_ack <= ~w_sda;
                        end else if (w_scl_fall) begin
                            if (r_rd_ack) begin
                                r_shift   <= w_rd_byte[6:0];
                                r_sda_low <= ~w_rd_byte[7];
                                r_rd_lo   <= ~r_rd_lo;
                                r_state   <= ST_RD_BYTE;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
`endif
                    ST_IDLE, ST_IGNORE: begin
                        r_sda_low <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_dac_target.sv
`timescale 1ns/1ps
// Self-checking bench for i2c_dac_target: directed vector table, hand sequences and random writes.
module tb_i2c_dac_target;

    localparam int Q = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        tb_sda_low = 1'b0;
    wire         sda;
    logic [11:0] dac_out;
    logic [1:0]  pd;
    logic        update;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int drv_cnt = 0;

    logic [11:0] m_dac = 12'h000;
    logic [1:0]  m_pd  = 2'b00;

    typedef struct {
        logic [7:0]       addr;
        int               n;
        logic [0:3][7:0]  d;
        logic [11:0]      exp_dac;
        logic [1:0]       exp_pd;
        int               exp_upd;
    } vec_t;

    vec_t tbl [4];

    pullup (sda);
    assign sda = tb_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_dac_target #(.TARGET_ADDR(7'h62), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .dac_out(dac_out), .pd(pd), .update(update), .busy(busy)
    );

    always @(negedge clk) begin
        if (update === 1'b1) upd_cnt++;
        if (sda === 1'b0 && !tb_sda_low) drv_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, required run to finish earlier");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bit_w(input logic b);
        tb_sda_low = ~b;
        #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        tb_sda_low = 1'b0;
        #Q; scl = 1'b1; #Q; tb_sda_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        tb_sda_low = 1'b1;
        #Q; scl = 1'b1; #Q; tb_sda_low = 1'b0; #(2*Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack_n);
        for (int i = 7; i >= 0; i--) bit_w(b[i]);
        tb_sda_low = 1'b0;
        #Q; scl = 1'b1; #Q; ack_n = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic rbyte(input logic give_ack, output logic [7:0] b);
        tb_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl = 1'b1; #Q; b[i] = sda; #Q; scl = 1'b0; #Q;
        end
        tb_sda_low = give_ack;
        #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        tb_sda_low = 1'b0;
    endtask

    // Full write transaction checked against the byte-pair model.
    task automatic run_txn(input logic [7:0] addr, input int n, input logic [0:3][7:0] d);
        logic match;
        logic a;
        int   u0, d0, pairs;
        match = (addr[7:1] == 7'h62) && !addr[0];
        u0 = upd_cnt;
        d0 = drv_cnt;
        pairs = 0;
        i2c_start;
        wbyte(addr, a);
        chk("addr_ack", {31'd0, a}, {31'd0, ~match});
        chk("busy_addr", {31'd0, busy}, {31'd0, match});
        for (int i = 0; i < n; i++) begin
            wbyte(d[i], a);
            chk("data_ack", {31'd0, a}, {31'd0, ~match});
            if (match && (i % 2 == 1)) begin
                m_dac = {d[i-1][3:0], d[i]};
                m_pd  = d[i-1][5:4];
                pairs++;
                chk("pair_dac", {20'd0, dac_out}, {20'd0, m_dac});
                chk("pair_pd", {30'd0, pd}, {30'd0, m_pd});
                chk("pair_upd", upd_cnt - u0, pairs);
            end
        end
        i2c_stop;
        chk("busy_stop", {31'd0, busy}, 32'd0);
        chk("txn_upd", upd_cnt - u0, pairs);
        chk("txn_dac", {20'd0, dac_out}, {20'd0, m_dac});
        chk("txn_pd", {30'd0, pd}, {30'd0, m_pd});
        if (!match) chk("no_drive", drv_cnt - d0, 0);
    endtask

    initial begin
        logic       a;
        logic [7:0] rb;
        int         u0, d0, n;
        logic [0:3][7:0] rd;
        logic [7:0] addr;

        tbl[0] = '{8'hC4, 2, {8'h0A, 8'hBC, 8'h00, 8'h00}, 12'hABC, 2'b00, 1};
        tbl[1] = '{8'hC6, 2, {8'h05, 8'h55, 8'h00, 8'h00}, 12'hABC, 2'b00, 0};
        tbl[2] = '{8'hC4, 1, {8'h31, 8'h00, 8'h00, 8'h00}, 12'hABC, 2'b00, 0};
        tbl[3] = '{8'hC4, 4, {8'h21, 8'h23, 8'h0F, 8'hFF}, 12'hFFF, 2'b00, 2};

        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("rst_dac", {20'd0, dac_out}, 32'd0);
        chk("rst_pd", {30'd0, pd}, 32'd0);
        chk("rst_update", {31'd0, update}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        rst = 1'b1;
        #(4*Q);

        for (int i = 0; i < 4; i++) begin
            u0 = upd_cnt;
            run_txn(tbl[i].addr, tbl[i].n, tbl[i].d);
            chk("tbl_dac", {20'd0, dac_out}, {20'd0, tbl[i].exp_dac});
            chk("tbl_pd", {30'd0, pd}, {30'd0, tbl[i].exp_pd});
            chk("tbl_upd", upd_cnt - u0, tbl[i].exp_upd);
        end

        // Readback of the code written just before.
        run_txn(8'hC4, 2, {8'h0A, 8'hBC, 8'h00, 8'h00});
        u0 = upd_cnt;
        i2c_start;
        wbyte(8'hC5, a);
`ifdef I2C_DAC_READBACK_EN
        chk("rd_addr_ack", {31'd0, a}, 32'd0);
        rbyte(1'b1, rb);
        chk("rd_byte1", {24'd0, rb}, 32'h0A);
        rbyte(1'b0, rb);
        chk("rd_byte2", {24'd0, rb}, 32'hBC);
`else
        chk("rd_addr_nack", {31'd0, a}, 32'd1);
        chk("rd_busy", {31'd0, busy}, 32'd0);
`endif
        i2c_stop;
        chk("rd_busy_stop", {31'd0, busy}, 32'd0);
        chk("rd_dac", {20'd0, dac_out}, 32'hABC);
        chk("rd_upd", upd_cnt - u0, 0);

        // Repeated START discards the pending first byte.
        u0 = upd_cnt;
        i2c_start;
        wbyte(8'hC4, a);
        wbyte(8'h0A, a);
        i2c_start;
        wbyte(8'hC4, a);
        chk("rs_addr_ack", {31'd0, a}, 32'd0);
        wbyte(8'h01, a);
        wbyte(8'h23, a);
        i2c_stop;
        chk("rs_dac", {20'd0, dac_out}, 32'h123);
        chk("rs_pd", {30'd0, pd}, 32'd0);
        chk("rs_upd", upd_cnt - u0, 1);
        m_dac = 12'h123;
        m_pd  = 2'b00;

        for (int k = 0; k < 20; k++) begin
            addr = ($urandom_range(0, 2) != 0) ? 8'hC4 : {7'($urandom), 1'b0};
            n = $urandom_range(0, 4);
            for (int j = 0; j < 4; j++) rd[j] = 8'($urandom);
            run_txn(addr, n, rd);
        end

        // Reset in the middle of the second data byte.
        run_txn(8'hC4, 2, {8'h3A, 8'h5C, 8'h00, 8'h00});
        i2c_start;
        wbyte(8'hC4, a);
        wbyte(8'h05, a);
        bit_w(1'b1);
        bit_w(1'b1);
        tb_sda_low = 1'b0;
        #Q; scl = 1'b1; #Q;
        rst = 1'b0;
        #10;
        chk("mid_rst_sda", {31'd0, sda}, 32'd1);
        chk("mid_rst_dac", {20'd0, dac_out}, 32'd0);
        chk("mid_rst_pd", {30'd0, pd}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_upd", {31'd0, update}, 32'd0);
        #(4*Q);
        rst = 1'b1;
        #(4*Q);
        m_dac = 12'h000;
        m_pd  = 2'b00;
        run_txn(8'hC4, 2, {8'h05, 8'h67, 8'h00, 8'h00});
        chk("post_rst_dac", {20'd0, dac_out}, 32'h567);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
